// File: rtl/strip_block_buffer_pkg.sv
// strip_block_buffer_pkg: shared types and read-FSM encodings for the raster-to-block reorder buffer
package strip_block_buffer_pkg;
  typedef logic rd_state_t;
  localparam rd_state_t RD_IDLE = 1'b0;
  localparam rd_state_t RD_SCAN = 1'b1;
  typedef struct packed {
    logic       full;
    logic       has_sop;
    logic       has_eop;
    logic [3:0] last_row;
  } bank_meta_t;
endpackage

// File: rtl/strip_block_buffer_addr_gen.sv
// strip_block_buffer_addr_gen: walks one strip in block order, clamping rows past the last written row
module strip_block_buffer_addr_gen #(
  parameter int WIDTH = 1280,
  parameter int BLK   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stall,
  input  logic [3:0]               last_row,
  output logic                     valid,
  output logic                     first,
  output logic                     blk_last,
  output logic                     last,
  output logic [$clog2(BLK)-1:0]   row,
  output logic [$clog2(WIDTH)-1:0] col
);
  localparam int RW = $clog2(BLK);
  localparam int CW = $clog2(WIDTH);
  localparam int BW = CW > RW ? CW - RW : 1;
  localparam logic [BW-1:0] B_MAX = BW'(WIDTH / BLK - 1);
  logic [BW-1:0] b;
  logic [RW-1:0] y, x;
  logic [3:0] ry;
  logic issue;
  assign issue = valid & ~stall;
  assign first = b == '0 && y == '0 && x == '0;
  assign blk_last = &x & &y;
  assign last = blk_last && b == B_MAX;
  assign ry = 4'(y) > last_row ? last_row : 4'(y);
  assign row = RW'(ry);
  assign col = CW'({b, x});
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid <= 1'b0;
      b <= '0;
      y <= '0;
      x <= '0;
    end else if (start) begin
      valid <= 1'b1;
      b <= '0;
      y <= '0;
      x <= '0;
    end else if (issue) begin
      valid <= ~last;
      x <= x + 1'b1;
      y <= &x ? y + 1'b1 : y;
      b <= blk_last ? b + 1'b1 : b;
    end
endmodule

// File: rtl/strip_block_buffer.sv
// strip_block_buffer: two-strip ping-pong buffer turning raster pixels into BLKxBLK blocks
// with valid/ready on both sides and a 2-entry skid buffer behind the 1-cycle RAM read.
module strip_block_buffer
  import strip_block_buffer_pkg::*;
#(
  parameter int WIDTH = 1280,
  parameter int BLK   = 8,
  parameter int CH    = 3,
  parameter int PIX_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*PIX_W-1:0] in_data,
  input  logic                in_sop,
  input  logic                in_eop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*PIX_W-1:0] out_data,
  output logic                out_sop,
  output logic                out_blk_last,
  output logic                out_eop,
  output logic                err_sync
);
  localparam int RW = $clog2(BLK);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = RW + CW;
  localparam int DW = CH * PIX_W;
  localparam logic [CW-1:0] H_MAX = CW'(WIDTH - 1);
  if (WIDTH % BLK != 0) begin : g_chk_width
    $error("WIDTH must be a multiple of BLK");
  end
  if (BLK < 2 || BLK > 16 || (BLK & (BLK - 1)) != 0) begin : g_chk_blk
    $error("BLK must be a power of 2 in 2..16");
  end
  logic [DW-1:0] mem [2**(AW+1)];
  bank_meta_t meta [2];
  rd_state_t state;
  logic wb, rb, cur_sop, acc, done, start, issue, rel, stall;
  logic [CW-1:0] h, hc;
  logic [RW-1:0] r, rc;
  logic g_valid, g_first, g_blk_last, g_last;
  logic [RW-1:0] g_row;
  logic [CW-1:0] g_col;
  logic [DW+2:0] rd_q, head;
  logic [DW+2:0] fifo [2];
  logic rd_vld, wp, rp, pop, push;
  logic [1:0] cnt;
  logic [2:0] occ;
  assign in_ready = rst_n & ~meta[wb].full;
  assign acc = in_valid & in_ready;
  assign hc = in_sop ? '0 : h;
  assign rc = in_sop ? '0 : r;
  assign done = (hc == H_MAX && rc == RW'(BLK - 1)) || in_eop;
  assign start = state == RD_IDLE && meta[rb].full;
  assign issue = g_valid & ~stall;
  assign rel = issue & g_last;
  strip_block_buffer_addr_gen #(.WIDTH(WIDTH), .BLK(BLK)) u_gen (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .last_row(meta[rb].last_row),
    .valid(g_valid), .first(g_first), .blk_last(g_blk_last), .last(g_last), .row(g_row), .col(g_col)
  );
  always_ff @(posedge clk) begin
    if (acc) mem[{wb, rc, hc}] <= in_data;
    if (issue) rd_q <= {meta[rb].has_eop & g_last, g_blk_last, meta[rb].has_sop & g_first, mem[{rb, g_row, g_col}]};
    if (push) fifo[wp] <= rd_q;
  end
  // Completion writes meta[wb] and release clears meta[rb]; they never alias since wb's bank is empty.
  always_ff @(posedge clk)
    if (!rst_n) begin
      meta[0] <= '0;
      meta[1] <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      h <= '0;
      r <= '0;
      cur_sop <= 1'b0;
      err_sync <= 1'b0;
      state <= RD_IDLE;
    end else begin
      err_sync <= acc & in_sop & (h != '0 || r != '0);
      if (rel) begin
        meta[rb].full <= 1'b0;
        rb <= ~rb;
      end
      if (acc && done) begin
        meta[wb] <= '{full: 1'b1, has_sop: in_sop | cur_sop, has_eop: in_eop, last_row: 4'(rc)};
        wb <= ~wb;
        h <= '0;
        r <= '0;
        cur_sop <= 1'b0;
      end else if (acc) begin
        h <= hc == H_MAX ? '0 : hc + 1'b1;
        r <= hc == H_MAX ? rc + 1'b1 : rc;
        cur_sop <= in_sop | cur_sop;
      end
      state <= state == RD_IDLE ? (start ? RD_SCAN : RD_IDLE) : (rel ? RD_IDLE : RD_SCAN);
    end
  // The freshly read word bypasses the skid buffer when it is empty, giving a 2-cycle first latency.
  assign out_valid = cnt != 2'd0 || rd_vld;
  assign head = cnt != 2'd0 ? fifo[rp] : rd_q;
  assign pop = out_valid & out_ready;
  assign push = rd_vld & ~(cnt == 2'd0 && pop);
  assign occ = 3'(cnt) + 3'(rd_vld) - 3'(pop);
  assign stall = occ > 3'd1;
  assign {out_eop, out_blk_last, out_sop, out_data} = out_valid ? head : '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_vld <= 1'b0;
      cnt <= 2'd0;
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (push) wp <= ~wp;
      if (pop && cnt != 2'd0) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop && cnt != 2'd0);
    end
endmodule

// File: tb/tb_strip_block_buffer.sv
// tb_strip_block_buffer: random-data directed scenarios checked against a strip/block ordering model
module tb_strip_block_buffer;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_sop, in_eop;
  logic out_valid, out_ready, out_sop, out_blk_last, out_eop, err_sync;
  logic [7:0] in_data, out_data;
  int total = 0, bad = 0, err_cnt = 0, stalls = 0, first_stall = -1, px_idx = 0, lat;
  bit dead = 0;
  logic [7:0] frm [384];
  logic [10:0] exp_q [$];
  logic [10:0] cur, held;
  bit hold = 0;

  strip_block_buffer #(.WIDTH(16), .BLK(8), .CH(1), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_blk_last(out_blk_last), .out_eop(out_eop),
    .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected output of a frame: strips of 8 rows, 2 blocks each, short strip rows clamp to its last row.
  task automatic push_expect(input int rows, input bit s, input bit e);
    for (int st = 0; st * 8 < rows; st++) begin
      int lr = rows - st * 8 >= 8 ? 7 : rows - st * 8 - 1;
      for (int b = 0; b < 2; b++)
        for (int y = 0; y < 8; y++)
          for (int x = 0; x < 8; x++) begin
            int rr = st * 8 + (y < lr ? y : lr);
            exp_q.push_back({e && st * 8 + 8 >= rows && b == 1 && y == 7 && x == 7, x == 7 && y == 7,
                             s && st == 0 && b == 0 && y == 0 && x == 0, frm[rr * 16 + b * 8 + x]});
          end
    end
  endtask

  task automatic send_px(input logic [7:0] d, input logic s, input logic e);
    int g = 0;
    if (dead) return;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_sop = s;
    in_eop = e;
    while (!in_ready && g < 2000) begin
      if (first_stall < 0) first_stall = px_idx;
      stalls++;
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 1);
      dead = 1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int rows, input bit s, input bit e, input int from);
    for (int i = from; i < rows * 16; i++) begin
      px_idx = i;
      send_px(frm[i], s && i == 0, e && i == rows * 16 - 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic randomize_frm();
    for (int i = 0; i < 384; i++) frm[i] = 8'($urandom);
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) hold = 0;
    else begin
      cur = {out_eop, out_blk_last, out_sop, out_data};
      if (hold) chk("hold_stable", {out_valid, cur}, {1'b1, held});
      if (err_sync) err_cnt++;
      if (out_valid && out_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out observed=%0h expected=none", cur);
        end
        if (exp_q.size() != 0) chk("out_px", cur, exp_q.pop_front());
      end
      hold = out_valid && !out_ready;
      held = cur;
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err_sync", 32'(err_sync), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    // 1: one strip, pixel = row*16+col, first-output latency
    for (int i = 0; i < 384; i++) frm[i] = 8'(i);
    push_expect(8, 1, 0);
    send_frame(8, 1, 0, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("first_latency", lat, 2);
    wait_drain("t1_drain");
    // 2: two continuous strips with eop, no backpressure on input
    randomize_frm();
    push_expect(16, 1, 1);
    stalls = 0;
    send_frame(16, 1, 1, 0);
    chk("t2_in_stalls", stalls, 0);
    wait_drain("t2_drain");
    // 3: downstream blocked for 300 clk while three strips arrive
    randomize_frm();
    push_expect(24, 1, 1);
    first_stall = -1;
    fork
      send_frame(24, 1, 1, 0);
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (300) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    chk("t3_first_stall", first_stall, 256);
    wait_drain("t3_drain");
    // 4: short final strip ending on row 2
    randomize_frm();
    push_expect(3, 1, 1);
    send_frame(3, 1, 1, 0);
    wait_drain("t4_drain");
    // 5: sop arrives 40 px into a strip; partial strip is discarded
    for (int i = 0; i < 40; i++) send_px(8'($urandom), i == 0, 1'b0);
    randomize_frm();
    push_expect(8, 1, 1);
    chk("t5_err_before", 32'(err_sync), 0);
    px_idx = 0;
    send_px(frm[0], 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_err_pulse", 32'(err_sync), 1);
    px_idx = 1;
    send_px(frm[1], 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_err_width", 32'(err_sync), 0);
    send_frame(8, 1, 1, 2);
    wait_drain("t5_drain");
    // 6: reset during SCAN with data on the output
    randomize_frm();
    push_expect(8, 1, 1);
    send_frame(8, 1, 1, 0);
    lat = 0;
    while (exp_q.size() > 100 && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    #1;
    chk("t6_valid_before_rst", 32'(out_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_in_ready_rst", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("t6_outs_after_rst", {out_valid, out_sop, out_blk_last, out_eop, out_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready_after", 32'(in_ready), 1);
    randomize_frm();
    push_expect(8, 1, 1);
    send_frame(8, 1, 1, 0);
    wait_drain("t6_drain");
    chk("err_sync_pulses", err_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
